// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel prescaler, strobes and frame counter
module vga_timing_gen #(
  parameter int CW       = 11,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIX_DIV  = 4,
  parameter int FW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          sync_clr,
  output logic          pix_tick,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic          frame_end,
  output logic [FW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_N  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_N  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  // Reject parameter sets that cannot describe a valid raster.
  if (PIX_DIV < 1) begin : g_chk_div
    $fatal(1, "vga_timing_gen: PIX_DIV must be at least 1");
  end
  if (((2 ** CW) < H_TOTAL) || ((2 ** CW) < V_TOTAL)) begin : g_chk_cw
    $fatal(1, "vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if ((H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
      (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1)) begin : g_chk_timing
    $fatal(1, "vga_timing_gen: every timing parameter must be at least 1");
  end

  logic [DW-1:0] div;
  logic [CW-1:0] h_nxt;
  logic [CW-1:0] v_nxt;
  logic          act_nxt;
  logic          hs_nxt;
  logic          vs_nxt;

  // Pixel strobe, qualified strobes and next raster position.
  always_comb begin
    pix_tick    = !reset && en && (div == DIV_LAST);
    line_start  = pix_tick && (hcount == '0);
    frame_start = pix_tick && (hcount == '0) && (vcount == '0);
    frame_end   = pix_tick && (hcount == H_LAST) && (vcount == V_LAST);
    h_nxt       = hcount;
    v_nxt       = vcount;
    if (sync_clr) begin
      h_nxt = '0;
      v_nxt = '0;
    end else if (pix_tick) begin
      if (hcount == H_LAST) begin
        h_nxt = '0;
        v_nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
      end else begin
        h_nxt = hcount + 1'b1;
      end
    end
  end

  // Decode the next position so the registered syncs line up with the counters.
  always_comb begin
    act_nxt = (h_nxt < H_ACT_N) && (v_nxt < V_ACT_N);
    hs_nxt  = ((h_nxt >= HS_BEG) && (h_nxt < HS_END)) ? HS_ON : ~HS_ON;
    vs_nxt  = ((v_nxt >= VS_BEG) && (v_nxt < VS_END)) ? VS_ON : ~VS_ON;
  end

  // Prescaler: counts clk cycles per pixel while enabled.
  always_ff @(posedge clk) begin
    if (reset || sync_clr) begin
      div <= '0;
    end else if (en) begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  // Raster counters and registered decode outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
      active <= 1'b1;
      hsync  <= ~HS_ON;
      vsync  <= ~VS_ON;
    end else begin
      hcount <= h_nxt;
      vcount <= v_nxt;
      active <= act_nxt;
      hsync  <= hs_nxt;
      vsync  <= vs_nxt;
    end
  end

  // Completed-frame counter; a raster restart suppresses the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (!sync_clr && frame_end) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a small raster
module tb_vga_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int DIV = 2, CW = 4, FW = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NP = HT * VT;

  logic          clk = 1'b1;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          sync_clr = 1'b0;
  logic          pix_tick;
  logic [CW-1:0] hcount;
  logic [CW-1:0] vcount;
  logic          hsync;
  logic          vsync;
  logic          active;
  logic          line_start;
  logic          frame_start;
  logic          frame_end;
  logic [FW-1:0] frame_cnt;

  vga_timing_gen #(
    .CW(CW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(0), .VS_POL(0), .PIX_DIV(DIV), .FW(FW)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr),
    .pix_tick(pix_tick), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .active(active),
    .line_start(line_start), .frame_start(frame_start), .frame_end(frame_end),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef logic [7+2*CW+FW-1:0] exp_t;
  exp_t q[$];

  int md = 0;
  int mp = 0;
  int mfc = 0;
  int total = 0;
  int bad = 0;

  // Reference: linear pixel index within the frame plus a clk-per-pixel phase.
  function automatic exp_t expect_now(input logic r, input logic e);
    int h;
    int v;
    logic pt;
    h  = mp % HT;
    v  = mp / HT;
    pt = !r && e && (md == DIV - 1);
    return {pt,
            pt && (h == 0),
            pt && (h == 0) && (v == 0),
            pt && (h == HT - 1) && (v == VT - 1),
            (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1,
            (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1,
            (h < HA) && (v < VA),
            CW'(h), CW'(v), FW'(mfc)};
  endfunction

  task automatic step(input logic r, input logic e, input logic s);
    reset    = r;
    en       = e;
    sync_clr = s;
    q.push_back(expect_now(r, e));
    @(posedge clk);
    if (r) begin
      md = 0; mp = 0; mfc = 0;
    end else if (s) begin
      md = 0; mp = 0;
    end else if (e) begin
      if (md == DIV - 1) begin
        md = 0;
        if (mp == NP - 1) mfc = (mfc + 1) % (1 << FW);
        mp = (mp + 1) % NP;
      end else begin
        md = md + 1;
      end
    end
    #1;
  endtask

  // Run with en=1 until the model reaches pixel index pos (and phase dv unless dv<0).
  task automatic run_to(input int pos, input int dv, input string name);
    int n;
    n = 0;
    while (!(mp == pos && (dv < 0 || md == dv)) && n < 4 * NP * DIV) begin
      step(1'b0, 1'b1, 1'b0);
      n++;
    end
    if (n >= 4 * NP * DIV) begin
      total++;
      bad++;
      $display("FAIL %s: position %0d/%0d not reached, at %0d/%0d", name, pos, dv, mp, md);
    end
  endtask

  // Monitor: every clk the DUT presents outputs; compare against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {pix_tick, line_start, frame_start, frame_end, hsync, vsync, active,
           hcount, vcount, frame_cnt};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL outputs t=%0t {pt,ls,fs,fe,hs,vs,act,h,v,fc} actual=%b_%0d_%0d_%0d expected=%b_%0d_%0d_%0d",
                 $time, a[7+2*CW+FW-1 -: 7], a[2*CW+FW-1 -: CW], a[CW+FW-1 -: CW], a[FW-1:0],
                 e[7+2*CW+FW-1 -: 7], e[2*CW+FW-1 -: CW], e[CW+FW-1 -: CW], e[FW-1:0]);
      end
    end
  end

  initial begin
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    md = 0; mp = 0; mfc = 0;
    step(1'b1, 1'b0, 1'b0);

    repeat (2 * NP * DIV + 10) step(1'b0, 1'b1, 1'b0);

    run_to(2, 0, "pause_h2");
    repeat (5) step(1'b0, 1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b1, 1'b0);

    run_to(3 * HT + 6, -1, "clr_h6v3");
    step(1'b0, 1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b1, 1'b0);

    run_to(NP - 1, DIV - 1, "clr_at_frame_end");
    step(1'b0, 1'b1, 1'b1);
    repeat (4) step(1'b0, 1'b1, 1'b0);

    run_to(NP - 1, DIV - 1, "end_before_reset");
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);

    repeat (4 * NP * DIV + 4) step(1'b0, 1'b1, 1'b0);

    repeat (3000) step(($urandom % 97) == 0, ($urandom % 4) != 0, ($urandom % 41) == 0);

    step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
